// File: rtl/fb_page_reader_pkg.sv
// fb_page_reader_pkg: framebuffer geometry shared with the trace plotter, and reader FSM states
package fb_page_reader_pkg;
  localparam int FB_WIDTH = 256;
  localparam int FB_PAGES = 16;
  localparam int FB_HEIGHT = FB_PAGES * 8;
  localparam int FB_ADDR_W = 15;
  localparam int FB_RD_LAT = 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, PRESENT} state_t;
endpackage

// File: rtl/fb_page_reader_if.sv
// fb_page_reader_if: control, framebuffer read port and byte stream of the page reader
interface fb_page_reader_if
  import fb_page_reader_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
);
  logic start;
  logic busy;
  logic frame_done;
  logic [ADDR_W-1:0] fb_addr;
  logic fb_ce;
  logic fb_dout;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (
    input start, fb_dout, out_ready,
    output busy, frame_done, fb_addr, fb_ce, out_data, out_valid
  );
  modport slave (
    output start, fb_dout, out_ready,
    input busy, frame_done, fb_addr, fb_ce, out_data, out_valid
  );
endinterface

// File: rtl/fb_rd_pipe.sv
// fb_rd_pipe: RD_LAT-deep delay line of {valid, bit index} tracking reads in flight
module fb_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic clrn,
  input logic in_valid,
  input logic [2:0] in_b,
  output logic out_valid,
  output logic [2:0] out_b
);
  logic [3:0] sr [RD_LAT];
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < RD_LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= {in_valid, in_b};
      for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
    end
  end
  assign {out_valid, out_b} = sr[RD_LAT-1];
endmodule

// File: rtl/fb_page_reader.sv
// fb_page_reader: scans the framebuffer in page order and streams packed 8-pixel column bytes
module fb_page_reader
  import fb_page_reader_pkg::*;
#(
  parameter int WIDTH = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int RD_LAT = FB_RD_LAT
) (
  input logic clk,
  input logic resetn,
  fb_page_reader_if.master bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int PCW = CW + $clog2(HEIGHT / 8);
  state_t state, state_n;
  logic [2:0] b, b_n, pb;
  logic [PCW-1:0] pc, pc_n;
  logic [7:0] data;
  logic pv, ce, valid, busy, done, xfer, last;
  assign xfer = state == PRESENT && bus.out_ready;
  assign last = &pc;
  always_comb begin
    state_n = state;
    b_n = b;
    pc_n = pc;
    case (state)
      IDLE: state_n = bus.start ? READ : IDLE;
      READ: begin
        b_n = b + 3'd1;
        state_n = b == 3'd7 ? DRAIN : READ;
      end
      DRAIN: state_n = pv && pb == 3'd7 ? PRESENT : DRAIN;
      PRESENT: begin
        pc_n = xfer ? pc + PCW'(1) : pc;
        state_n = xfer ? (last ? IDLE : READ) : PRESENT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      b <= '0;
      pc <= '0;
      data <= '0;
      ce <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      b <= b_n;
      pc <= pc_n;
      ce <= state_n == READ;
      valid <= state_n == PRESENT;
      busy <= state_n != IDLE;
      done <= xfer && last;
      if (pv) data[pb] <= bus.fb_dout;
    end
  end
  fb_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk(clk),
    .clrn(resetn),
    .in_valid(ce),
    .in_b(b),
    .out_valid(pv),
    .out_b(pb)
  );
  assign bus.fb_addr = ADDR_W'({pc[PCW-1:CW], b, pc[CW-1:0]});
  assign bus.fb_ce = ce;
  assign bus.out_data = data;
  assign bus.out_valid = valid;
  assign bus.busy = busy;
  assign bus.frame_done = done;
endmodule

// File: tb/tb_fb_page_reader.sv
// tb_fb_page_reader: scoreboard bench for a default-geometry reader and a small RD_LAT=3 reader
module tb_fb_page_reader;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fb_page_reader_if #(.ADDR_W(15)) ia ();
  fb_page_reader_if #(.ADDR_W(8)) ib ();
  fb_page_reader dut_a (.clk(clk), .resetn(resetn), .bus(ia.master));
  fb_page_reader #(.WIDTH(16), .HEIGHT(16), .ADDR_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ib.master));
  bit mem_a [32768];
  bit mem_b [256];
  logic b1, b2;
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  always @(posedge clk) begin
    if (ia.fb_ce) ia.fb_dout <= mem_a[ia.fb_addr];
    if (ib.fb_ce) b1 <= mem_b[ib.fb_addr];
    b2 <= b1;
    ib.fb_dout <= b2;
  end
  task automatic fill_a();
    logic [7:0] e;
    for (int p = 0; p < 16; p++)
      for (int x = 0; x < 256; x++) begin
        for (int k = 0; k < 8; k++) e[k] = mem_a[(p * 8 + k) * 256 + x];
        q_a.push_back(e);
      end
  endtask
  task automatic fill_b();
    for (int p = 0; p < 2; p++)
      for (int x = 0; x < 16; x++) q_b.push_back(x % 2 == 1 ? 8'h55 : 8'hAA);
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ia.fb_addr, ia.fb_ce, ia.out_data, ia.out_valid, ia.busy, ia.frame_done} !== '0) begin
      failures++;
      $display("FAIL reset_a outputs=%h expected 0", {ia.fb_addr, ia.fb_ce, ia.out_data, ia.out_valid, ia.busy, ia.frame_done});
    end
    checks++;
    if ({ib.fb_addr, ib.fb_ce, ib.out_data, ib.out_valid, ib.busy, ib.frame_done} !== '0) begin
      failures++;
      $display("FAIL reset_b outputs=%h expected 0", {ib.fb_addr, ib.fb_ce, ib.out_data, ib.out_valid, ib.busy, ib.frame_done});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_frame_a();
    int cyc = 0, n = 0, first_v = 0, done_cyc = 0;
    for (int i = 0; i < 32768; i++) mem_a[i] = 1'b0;
    mem_a[0] = 1'b1;
    for (int x = 0; x < 256; x++) mem_a[7 * 256 + x] = 1'b1;
    for (int y = 0; y < 128; y++) mem_a[y * 256 + 255] = 1'b1;
    fill_a();
    ia.out_ready = 1'b1;
    ia.start = 1'b1;
    while (done_cyc == 0 && cyc < 42000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        ia.start = 1'b0;
        checks++;
        if (ia.fb_ce !== 1'b1 || ia.fb_addr !== 15'd0 || ia.busy !== 1'b1) begin
          failures++;
          $display("FAIL a_first_read ce=%b addr=%h busy=%b expected 1/0/1", ia.fb_ce, ia.fb_addr, ia.busy);
        end
      end
      if (cyc == 5000) ia.start = 1'b1;
      if (cyc == 5001) ia.start = 1'b0;
      if (ia.out_valid && first_v == 0) first_v = cyc;
      if (ia.out_valid && ia.out_ready) begin
        checks++;
        if (q_a.size() == 0 || ia.out_data !== q_a[0]) begin
          failures++;
          $display("FAIL a_byte[%0d] got=%h expected=%h", n, ia.out_data, q_a.size() ? q_a[0] : 8'hxx);
        end
        if (q_a.size() != 0) void'(q_a.pop_front());
        n++;
      end
      if (ia.frame_done) done_cyc = cyc;
    end
    checks++;
    if (first_v != 10) begin failures++; $display("FAIL a_first_valid cycle=%0d expected=10", first_v); end
    checks++;
    if (n != 4096) begin failures++; $display("FAIL a_byte_count got=%0d expected=4096", n); end
    checks++;
    if (done_cyc != 40961) begin failures++; $display("FAIL a_frame_done cycle=%0d expected=40961", done_cyc); end
    checks++;
    if (ia.busy !== 1'b0) begin failures++; $display("FAIL a_busy_at_done got=%b expected=0", ia.busy); end
    ia.start = 1'b1;
    ia.out_ready = 1'b0;
    fill_a();
    @(negedge clk);
    ia.start = 1'b0;
    checks++;
    if (ia.busy !== 1'b1 || ia.fb_ce !== 1'b1 || ia.fb_addr !== 15'd0) begin
      failures++;
      $display("FAIL a_restart_on_done busy=%b ce=%b addr=%h expected 1/1/0", ia.busy, ia.fb_ce, ia.fb_addr);
    end
  endtask
  task automatic test_stall_a();
    int cyc = 1, n = 0, guard = 0;
    logic [7:0] held;
    while (!ia.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 10) begin failures++; $display("FAIL a_stall_first_valid cycle=%0d expected=10", cyc); end
    held = ia.out_data;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (ia.out_data !== held || ia.fb_ce !== 1'b0 || ia.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL a_stall data=%h ce=%b valid=%b expected %h/0/1", ia.out_data, ia.fb_ce, ia.out_valid, held);
      end
    end
    ia.out_ready = 1'b1;
    checks++;
    if (q_a.size() == 0 || ia.out_data !== q_a[0]) begin
      failures++;
      $display("FAIL a_stall_byte got=%h expected=%h", ia.out_data, q_a.size() ? q_a[0] : 8'hxx);
    end
    if (q_a.size() != 0) void'(q_a.pop_front());
    n = 1;
    @(negedge clk);
    checks++;
    if (ia.fb_ce !== 1'b1 || ia.out_valid !== 1'b0 || ia.fb_addr !== 15'd1) begin
      failures++;
      $display("FAIL a_after_stall ce=%b valid=%b addr=%h expected 1/0/1", ia.fb_ce, ia.out_valid, ia.fb_addr);
    end
    while (n < 1000 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (ia.out_valid && ia.out_ready) begin
        checks++;
        if (q_a.size() == 0 || ia.out_data !== q_a[0]) begin
          failures++;
          $display("FAIL a2_byte[%0d] got=%h expected=%h", n, ia.out_data, q_a.size() ? q_a[0] : 8'hxx);
        end
        if (q_a.size() != 0) void'(q_a.pop_front());
        n++;
      end
    end
    checks++;
    if (n != 1000) begin failures++; $display("FAIL a2_byte_count got=%0d expected=1000", n); end
    repeat (3) @(negedge clk);
    checks++;
    if (ia.fb_ce !== 1'b1) begin failures++; $display("FAIL a_mid_read ce=%b expected=1", ia.fb_ce); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if ({ia.fb_addr, ia.fb_ce, ia.out_data, ia.out_valid, ia.busy, ia.frame_done} !== '0) begin
      failures++;
      $display("FAIL a_mid_reset outputs=%h expected 0", {ia.fb_addr, ia.fb_ce, ia.out_data, ia.out_valid, ia.busy, ia.frame_done});
    end
    repeat (15) @(negedge clk);
    checks++;
    if (ia.busy !== 1'b0 || ia.fb_ce !== 1'b0 || ia.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL a_idle_after_reset busy=%b ce=%b valid=%b expected 0/0/0", ia.busy, ia.fb_ce, ia.out_valid);
    end
    q_a.delete();
    ia.out_ready = 1'b0;
  endtask
  task automatic run_frame_b(input int stop_at, input int busy_pulse);
    int cyc = 0, n = 0, done_cyc = 0;
    ib.out_ready = 1'b1;
    ib.start = 1'b1;
    while (done_cyc == 0 && n < stop_at && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) ib.start = 1'b0;
      if (cyc == busy_pulse) ib.start = 1'b1;
      if (cyc == busy_pulse + 1) ib.start = 1'b0;
      if (ib.out_valid && ib.out_ready) begin
        checks++;
        if (q_b.size() == 0 || ib.out_data !== q_b[0] || cyc != 12 * (n + 1)) begin
          failures++;
          $display("FAIL b_byte[%0d] got=%h at cycle %0d expected=%h at cycle %0d", n, ib.out_data, cyc, q_b.size() ? q_b[0] : 8'hxx, 12 * (n + 1));
        end
        if (q_b.size() != 0) void'(q_b.pop_front());
        n++;
      end
      if (ib.frame_done) done_cyc = cyc;
    end
    if (stop_at > 32) begin
      checks++;
      if (n != 32 || done_cyc != 385 || ib.busy !== 1'b0) begin
        failures++;
        $display("FAIL b_frame bytes=%0d done_cycle=%0d busy=%b expected 32/385/0", n, done_cyc, ib.busy);
      end
    end else begin
      checks++;
      if (n != stop_at) begin failures++; $display("FAIL b_partial bytes=%0d expected=%0d", n, stop_at); end
    end
  endtask
  task automatic test_checker_b();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mem_b[y * 16 + x] = 1'((x ^ y) & 1);
    fill_b();
    run_frame_b(100, 50);
    checks++;
    if (q_b.size() != 0) begin failures++; $display("FAIL b_queue_left got=%0d expected=0", q_b.size()); end
  endtask
  task automatic test_reset_restart_b();
    @(negedge clk);
    fill_b();
    run_frame_b(10, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (ib.fb_ce !== 1'b1) begin failures++; $display("FAIL b_mid_read ce=%b expected=1", ib.fb_ce); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if ({ib.fb_addr, ib.fb_ce, ib.out_data, ib.out_valid, ib.busy, ib.frame_done} !== '0) begin
      failures++;
      $display("FAIL b_mid_reset outputs=%h expected 0", {ib.fb_addr, ib.fb_ce, ib.out_data, ib.out_valid, ib.busy, ib.frame_done});
    end
    q_b.delete();
    fill_b();
    run_frame_b(100, 0);
  endtask
  initial begin
    ia.start = 1'b0;
    ia.out_ready = 1'b0;
    ib.start = 1'b0;
    ib.out_ready = 1'b0;
    test_reset();
    test_frame_a();
    test_stall_a();
    test_checker_b();
    test_reset_restart_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
